// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus of the fetch unit.
//   imem_req    request valid (fetch unit -> memory)
//   imem_addr   request word address (fetch unit -> memory)
//   imem_gnt    request accepted when imem_req & imem_gnt (memory -> fetch unit)
//   imem_rvalid response valid, returned in request order (memory -> fetch unit)
//   imem_rdata  response word (memory -> fetch unit)
interface if_fetch_unit_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [WIDTH-1:0]  imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end of the 5-stage MIPS pipeline.
// Owns the PC, issues in-order requests to instruction memory, buffers the
// returned words in a small queue and presents one {pc, instr} per cycle to
// the IF/ID register. Honours the hazard-unit stall and the EX branch redirect.
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   stall          1 = IF/ID holds, head entry is not popped
//   branch         1 = redirect fetch to branch_target and flush everything
//   branch_target  redirect address (word aligned)
//   imem           instruction-memory bus (master side)
//   if_valid       queue head valid
//   if_instr       head instruction, 0 (NOP) when !if_valid
//   if_pc          head PC, 0 when !if_valid
module if_fetch_unit #(
   parameter int unsigned       WIDTH    = 32,
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       DEPTH    = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              branch,
   input  logic [ADDR_W-1:0] branch_target,
   if_fetch_unit_if.master   imem,
   output logic              if_valid,
   output logic [WIDTH-1:0]  if_instr,
   output logic [ADDR_W-1:0] if_pc
);
   localparam int unsigned   PTR_W   = $clog2(DEPTH);
   localparam int unsigned   CNT_W   = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [CNT_W-1:0]  occ_q, occ_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
   logic [WIDTH-1:0]  instr_mem_q [DEPTH];

   logic [CNT_W:0]    used;
   logic              req;
   logic              accept;
   logic              rvalid;
   logic              push;
   logic              pop;

   // A request is only issued when a queue slot is guaranteed for its
   // response; a pop in the same cycle does not free credit.
   assign used   = {1'b0, inflight_q} + {1'b0, occ_q};
   assign req    = !reset && !branch && (used < DEPTH_V);
   assign accept = req && imem.imem_gnt;
   assign rvalid = imem.imem_rvalid;
   assign push   = rvalid && (drop_q == '0) && !branch;

   assign imem.imem_req  = req;
   assign imem.imem_addr = pc_q;

   assign if_valid = !reset && (occ_q != '0);
   assign if_instr = if_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign if_pc    = if_valid ? pc_mem_q[rd_ptr_q]    : '0;
   assign pop      = if_valid && !stall && !branch;

   always_comb begin
      pc_d       = pc_q;
      resp_pc_d  = resp_pc_q;
      drop_d     = drop_q;
      occ_d      = occ_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(rvalid);
      if (branch) begin
         pc_d      = branch_target;
         resp_pc_d = branch_target;
         // inflight already counts responses still pending discard, so every
         // outstanding response becomes stale; one arriving now is dropped here.
         drop_d    = inflight_q - CNT_W'(rvalid);
         occ_d     = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
      end else begin
         if (accept) begin
            pc_d = pc_q + ADDR_W'(4);
         end
         if (rvalid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CNT_W'(1);
            end else begin
               resp_pc_d = resp_pc_q + ADDR_W'(4);
            end
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         occ_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         pc_q       <= pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         occ_q      <= occ_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Queue storage needs no reset: occupancy gates everything read from it.
   always_ff @(posedge clock) begin
      if (push && !reset) begin
         pc_mem_q[wr_ptr_q]    <= resp_pc_q;
         instr_mem_q[wr_ptr_q] <= imem.imem_rdata;
      end
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
   localparam int unsigned DEPTH = 2;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } mreq_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch;
   logic [31:0] branch_target;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   if_fetch_unit_if #(.WIDTH(32), .ADDR_W(32)) bus ();

   if_fetch_unit #(
      .WIDTH   (32),
      .ADDR_W  (32),
      .RESET_PC(32'h0),
      .DEPTH   (DEPTH)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .branch       (branch),
      .branch_target(branch_target),
      .imem         (bus),
      .if_valid     (if_valid),
      .if_instr     (if_instr),
      .if_pc        (if_pc)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          lat    = 1;
   mreq_t       mq[$];
   logic [63:0] expq[$];
   logic [31:0] m_pc;
   logic [31:0] m_rpc;
   logic        o_req, o_valid;
   logic [31:0] o_addr, o_instr, o_pc;

   function automatic logic [31:0] word(input logic [31:0] a);
      return ~a ^ {a[15:0], a[31:16]};
   endfunction

   // One clock cycle: memory model drives the response, outputs are sampled,
   // the scoreboard compares the head, then the model advances.
   task automatic tick();
      bit          rv;
      bit          rv_stale;
      logic        exp_req;
      mreq_t       r;
      rv       = 0;
      rv_stale = 0;
      bus.imem_rdata = '0;
      if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
         rv             = 1;
         rv_stale       = mq[0].stale;
         bus.imem_rdata = word(mq[0].addr);
      end
      bus.imem_rvalid = rv;
      #1;
      o_req   = bus.imem_req;
      o_addr  = bus.imem_addr;
      o_valid = if_valid;
      o_instr = if_instr;
      o_pc    = if_pc;
      if (reset) begin
         mq.delete();
         expq.delete();
         m_pc  = 32'h0;
         m_rpc = 32'h0;
      end else begin
         checks++;
         if (if_valid !== (expq.size() != 0)) begin
            errors++;
            $display("FAIL sb_valid: if_valid=%b required %b (cycle %0d)", if_valid, expq.size() != 0, cyc);
         end
         if (if_valid === 1'b1 && expq.size() != 0) begin
            checks++;
            if ({if_pc, if_instr} !== expq[0]) begin
               errors++;
               $display("FAIL sb_head: pc=%h instr=%h required pc=%h instr=%h (cycle %0d)",
                        if_pc, if_instr, expq[0][63:32], expq[0][31:0], cyc);
            end
         end
         exp_req = !branch && ((mq.size() + expq.size()) < DEPTH);
         checks++;
         if (bus.imem_req !== exp_req) begin
            errors++;
            $display("FAIL sb_req: imem_req=%b required %b (cycle %0d)", bus.imem_req, exp_req, cyc);
         end
         if (rv) mq.delete(0);
         if (branch) begin
            expq.delete();
            foreach (mq[i]) mq[i].stale = 1;
            m_pc  = branch_target;
            m_rpc = branch_target;
         end else begin
            if (if_valid === 1'b1 && !stall && expq.size() != 0) expq.delete(0);
            if (rv && !rv_stale) begin
               expq.push_back({m_rpc, word(m_rpc)});
               m_rpc = m_rpc + 32'd4;
            end
            if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
               checks++;
               if (bus.imem_addr !== m_pc) begin
                  errors++;
                  $display("FAIL sb_addr: imem_addr=%h required %h (cycle %0d)", bus.imem_addr, m_pc, cyc);
               end
               r.addr  = bus.imem_addr;
               r.due   = cyc + lat;
               r.stale = 0;
               mq.push_back(r);
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (o_req !== 1'b0 || o_valid !== 1'b0 || o_instr !== 32'h0 || o_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b valid=%b instr=%h pc=%h required 0 0 0 0", o_req, o_valid, o_instr, o_pc);
         end
      end
   endtask

   task automatic test_startup();
      bit found = 0;
      reset = 0;
      tick();
      checks++;
      if (o_req !== 1'b1 || o_addr !== 32'h0) begin
         errors++;
         $display("FAIL first_req: req=%b addr=%h required 1 00000000", o_req, o_addr);
      end
      tick();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL startup_gap: if_valid=%b required 0", o_valid);
      end
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== word(32'h0)) begin
         errors++;
         $display("FAIL first_instr: valid=%b pc=%h instr=%h required 1 00000000 %h", o_valid, o_pc, o_instr, word(32'h0));
      end
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (o_valid === 1'b1) begin
            found = 1;
            checks++;
            if (o_pc !== 32'h4) begin
               errors++;
               $display("FAIL second_instr: pc=%h required 00000004", o_pc);
            end
         end
      end
      if (!found) begin
         errors++;
         $display("FAIL second_instr: timeout, required pc 00000004");
      end
   endtask

   task automatic test_stall();
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (if_valid === 1'b1 && if_pc === 32'h8) found = 1;
         else tick();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL stall_wait: head pc 00000008 never shown, last pc=%h", if_pc);
      end
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (o_valid !== 1'b1 || o_pc !== 32'h8) begin
            errors++;
            $display("FAIL stall_hold: valid=%b pc=%h required 1 00000008", o_valid, o_pc);
         end
      end
      checks++;
      if (o_req !== 1'b0) begin
         errors++;
         $display("FAIL stall_req: imem_req=%b required 0", o_req);
      end
      stall = 0;
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h8) begin
         errors++;
         $display("FAIL stall_release: valid=%b pc=%h required 1 00000008", o_valid, o_pc);
      end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (o_valid === 1'b1) found = 1;
      end
      checks++;
      if (!found || o_pc !== 32'hC) begin
         errors++;
         $display("FAIL stall_next: pc=%h found=%0d required 0000000c", o_pc, found);
      end
   endtask

   task automatic test_branch_inflight();
      bit found = 0;
      reset = 1;
      tick();
      reset = 0;
      lat   = 3;
      tick();
      tick();
      branch        = 1;
      branch_target = 32'h100;
      tick();
      branch = 0;
      checks++;
      if (o_req !== 1'b0) begin
         errors++;
         $display("FAIL branch_req: imem_req=%b required 0", o_req);
      end
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (o_valid === 1'b1) found = 1;
      end
      checks++;
      if (!found || o_pc !== 32'h100 || o_instr !== word(32'h100)) begin
         errors++;
         $display("FAIL branch_target: pc=%h instr=%h found=%0d required 00000100 %h", o_pc, o_instr, found, word(32'h100));
      end
   endtask

   task automatic test_gnt_hold();
      bit          found = 0;
      logic [31:0] a;
      lat = 1;
      for (int i = 0; i < 20 && !found; i++) begin
         if (bus.imem_req === 1'b1 && if_valid === 1'b1) found = 1;
         else tick();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL gnt_wait: no cycle with req and valid head");
      end
      bus.imem_gnt = 0;
      a = bus.imem_addr;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (o_req !== 1'b1 || o_addr !== a) begin
            errors++;
            $display("FAIL gnt_hold: req=%b addr=%h required 1 %h", o_req, o_addr, a);
         end
      end
      checks++;
      if (o_valid !== 1'b0 || o_instr !== 32'h0 || o_pc !== 32'h0) begin
         errors++;
         $display("FAIL gnt_drain: valid=%b instr=%h pc=%h required 0 0 0", o_valid, o_instr, o_pc);
      end
      bus.imem_gnt = 1;
   endtask

   task automatic test_branch_rvalid_pop();
      bit found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (if_valid === 1'b1 && mq.size() > 0 && mq[0].due <= cyc && !mq[0].stale) found = 1;
         else tick();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL brp_wait: no cycle with rvalid and valid head");
      end
      branch        = 1;
      branch_target = 32'h200;
      tick();
      branch = 0;
      checks++;
      if (o_req !== 1'b0 || o_valid !== 1'b1) begin
         errors++;
         $display("FAIL brp_cycle: req=%b valid=%b required 0 1", o_req, o_valid);
      end
      tick();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL brp_empty: if_valid=%b required 0", o_valid);
      end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (o_valid === 1'b1) found = 1;
      end
      checks++;
      if (!found || o_pc !== 32'h200) begin
         errors++;
         $display("FAIL brp_target: pc=%h found=%0d required 00000200", o_pc, found);
      end
   endtask

   task automatic test_reset_mid();
      repeat (5) tick();
      reset = 1;
      tick();
      checks++;
      if (o_req !== 1'b0 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_cycle: req=%b valid=%b required 0 0", o_req, o_valid);
      end
      reset = 0;
      tick();
      checks++;
      if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_after: valid=%b req=%b addr=%h required 0 1 00000000", o_valid, o_req, o_addr);
      end
   endtask

   task automatic test_wrap();
      bit saw_hi   = 0;
      bit saw_zero = 0;
      branch        = 1;
      branch_target = 32'hFFFF_FFF8;
      tick();
      branch = 0;
      for (int i = 0; i < 40 && !saw_zero; i++) begin
         tick();
         if (o_valid === 1'b1 && o_pc === 32'hFFFF_FFFC) saw_hi = 1;
         if (o_valid === 1'b1 && o_pc === 32'h0 && saw_hi) saw_zero = 1;
      end
      checks++;
      if (!saw_zero) begin
         errors++;
         $display("FAIL wrap: saw_fffffffc=%0d saw_00000000=%0d required 1 1", saw_hi, saw_zero);
      end
   endtask

   task automatic test_random();
      int pops = 0;
      for (int i = 0; i < 600; i++) begin
         lat           = 1 + (i / 150) % 3;
         bus.imem_gnt  = ($urandom_range(0, 9) < 8);
         stall         = ($urandom_range(0, 9) < 3);
         branch        = ($urandom_range(0, 19) == 0);
         branch_target = $urandom & 32'hFFFF_FFFC;
         reset         = ($urandom_range(0, 199) == 0);
         if (if_valid === 1'b1 && !stall && !branch && !reset) pops++;
         tick();
      end
      reset        = 0;
      stall        = 0;
      branch       = 0;
      bus.imem_gnt = 1;
      repeat (10) tick();
      checks++;
      if (pops < 50) begin
         errors++;
         $display("FAIL random_progress: pops=%0d required >= 50", pops);
      end
   endtask

   initial begin
      reset           = 1;
      stall           = 0;
      branch          = 0;
      branch_target   = 32'h0;
      bus.imem_gnt    = 1;
      bus.imem_rvalid = 0;
      bus.imem_rdata  = 32'h0;
      m_pc            = 32'h0;
      m_rpc           = 32'h0;
      test_reset();
      test_startup();
      test_stall();
      test_branch_inflight();
      test_gnt_hold();
      test_branch_rvalid_pop();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
